// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution datapath and its result reader.
package conv_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int SIZE_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo2_sv.sv
// Two-entry first-word-fall-through buffer; head entry is always presented on data_o.
module fifo2_sv #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_ok  = pop_i && (count_q != 2'd0);
    // a push into a full buffer is only legal when the head leaves in the same cycle
    push_ok = push_i && ((count_q != 2'd2) || pop_ok);
    case ({push_ok, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) head_d = data_i;
        else                 tail_d = data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = data_i;
        end else begin
          head_d = tail_q;
          tail_d = data_i;
        end
      end
      default: ;
    endcase
  end

  assign data_o  = head_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/conv_result_reader.sv
// Drains N = sizeX+sizeY-1 convolution results from the Z RAM onto a valid/ready stream.
//   state    | meaning
//   ST_IDLE  | waiting for start_i
//   ST_READ  | issuing RAM reads under the 2-slot credit limit
//   ST_DRAIN | all reads issued, emptying the buffer
//   ST_FIN   | one-cycle done pulse
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SIZE_WIDTH = SIZE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [SIZE_WIDTH-1:0] sizeX,
  input  logic [SIZE_WIDTH-1:0] sizeY,
  output logic [ADDR_WIDTH-1:0] memZ_addr,
  input  logic [DATA_WIDTH-1:0] dataZ_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  busy,
  output logic                  done
);

  rd_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [ADDR_WIDTH-1:0] n_calc;
  logic [2:0]            used;
  logic                  issue;
  logic                  last_issue;
  logic                  xfer;
  logic [DATA_WIDTH:0]   head;
  logic                  head_valid;
  logic [1:0]            fifo_count;

  assign n_calc = ((sizeX == '0) || (sizeY == '0)) ? '0 :
                  ADDR_WIDTH'(sizeX) + ADDR_WIDTH'(sizeY) - ADDR_WIDTH'(1);

  // the slot freed by this cycle's transfer is reusable, which keeps one word per clock
  assign used       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, xfer};
  assign issue      = (state_q == ST_READ) && (used < 3'd2);
  assign last_issue = issue && (rd_ptr_q == n_q - ADDR_WIDTH'(1));
  assign xfer       = m_valid_o && m_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      n_q             <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      rd_ptr_q        <= rd_ptr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          n_d      = n_calc;
          rd_ptr_d = '0;
          state_d  = (n_calc == '0) ? ST_FIN : ST_READ;
        end
      end
      ST_READ: begin
        // the pointer parks on N-1 so the address bus never leaves the result range
        if (issue) begin
          if (last_issue) state_d  = ST_DRAIN;
          else            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (xfer && head[DATA_WIDTH]) state_d = ST_FIN;
      end
      ST_FIN: begin
        rd_ptr_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_valid_o = head_valid && ((state_q == ST_READ) || (state_q == ST_DRAIN));
    m_data_o  = head[DATA_WIDTH-1:0];
    m_last_o  = head[DATA_WIDTH] && m_valid_o;
    busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
    done      = (state_q == ST_FIN);
    memZ_addr = rd_ptr_q;
  end

  fifo2_sv #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (inflight_q),
    .data_i ({inflight_last_q, dataZ_i}),
    .pop_i  (xfer),
    .data_o (head),
    .valid_o(head_valid),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_conv_result_reader.sv
// Self-checking bench for conv_result_reader: vector table of runs plus reset/abort sequences.
module tb_conv_result_reader;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [SW-1:0] sizeX, sizeY;
  logic [AW-1:0] memZ_addr;
  logic [DW-1:0] dataZ_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o, m_ready_i, m_last_o, busy, done;

  conv_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .sizeX(sizeX), .sizeY(sizeY),
    .memZ_addr(memZ_addr), .dataZ_i(dataZ_i), .m_data_o(m_data_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] zmem [64];

  // synchronous-read RAM model: data appears one clock after the address
  always @(posedge clk) dataZ_i <= zmem[memZ_addr];

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [SW-1:0] sx;
    logic [SW-1:0] sy;
    int            mode;
    int            exp_n;
    bit            restart;
  } vec_t;
  vec_t vecs[9];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {memZ_addr, m_data_o, m_valid_o, m_last_o, busy, done}, 64'd0);
  endtask

  task automatic run(input logic [SW-1:0] sx, input logic [SW-1:0] sy, input int mode,
                     input int exp_n, input bit restart);
    int t, first_v, last_x, done_t, xfers, max_addr;
    bit stalled;
    logic [DW-1:0] held_d;
    logic held_l;
    exp_t e;
    sbq.delete();
    for (int i = 0; i < exp_n; i++) begin
      e.d = zmem[i];
      e.l = (i == exp_n - 1);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start_i = 1'b1; sizeX = sx; sizeY = sy; m_ready_i = 1'b1;
    t = -1; first_v = -1; last_x = -1; done_t = -1; xfers = 0; max_addr = 0;
    stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (done_t < 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
      start_i = restart && (t == 5);
      if (restart && t == 5) begin sizeX = 5'd2; sizeY = 5'd2; end
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = (t % 2 == 0);
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (stalled)
        check("stall_hold", {m_valid_o, m_last_o, m_data_o}, {1'b1, held_l, held_d});
      if (busy && int'(memZ_addr) > max_addr) max_addr = int'(memZ_addr);
      if (m_valid_o && first_v < 0) first_v = t;
      stalled = m_valid_o && !m_ready_i;
      held_d  = m_data_o;
      held_l  = m_last_o;
      if (m_valid_o && m_ready_i) begin
        if (sbq.size() == 0) begin
          check("extra_word", 64'd1, 64'd0);
        end else begin
          e = sbq.pop_front();
          check("word_data", m_data_o, e.d);
          check("word_last", m_last_o, e.l);
        end
        xfers++;
        last_x = t;
      end
      if (done) begin
        done_t = t;
        check("busy_low_in_fin", busy, 1'b0);
      end
    end
    start_i = 1'b0;
    if (done_t < 0) check("done_timeout", 64'd0, 64'd1);
    check("word_count", xfers, exp_n);
    check("sb_empty", sbq.size(), 0);
    if (exp_n > 0) begin
      check("first_valid_latency", first_v, 2);
      check("done_after_last", done_t, last_x + 1);
      check("max_addr", max_addr, exp_n - 1);
      if (mode == 0) check("back_to_back", last_x, exp_n + 1);
    end else begin
      check("no_valid", first_v, -1);
      check("done_latency_n0", done_t, 0);
    end
    @(posedge clk); #1;
    check("idle_after_fin", {done, busy, m_valid_o}, 3'b000);
  endtask

  initial begin
    int xf;
    bit reached;
    for (int i = 0; i < 64; i++) zmem[i] = {8'($urandom_range(1, 255)), 8'(i)};

    vecs[0] = '{5'd5,  5'd10, 0, 14, 1'b0};
    vecs[1] = '{5'd5,  5'd10, 1, 14, 1'b0};
    vecs[2] = '{5'd0,  5'd7,  0, 0,  1'b0};
    vecs[3] = '{5'd5,  5'd10, 0, 14, 1'b1};
    vecs[4] = '{5'd31, 5'd31, 0, 61, 1'b0};
    vecs[5] = '{5'd1,  5'd1,  2, 1,  1'b0};
    vecs[6] = '{5'd2,  5'd1,  1, 2,  1'b0};
    vecs[7] = '{5'd4,  5'd0,  0, 0,  1'b0};
    vecs[8] = '{5'd31, 5'd31, 2, 61, 1'b0};

    rst = 1'b1; start_i = 1'b0; sizeX = '0; sizeY = '0; m_ready_i = 1'b0;
    #12;
    check_outputs_zero("reset_state");
    rst = 1'b0;

    for (int v = 0; v < 9; v++)
      run(vecs[v].sx, vecs[v].sy, vecs[v].mode, vecs[v].exp_n, vecs[v].restart);

    // abort a run after four transfers, then confirm a clean restart from address 0
    @(posedge clk); #1;
    start_i = 1'b1; sizeX = 5'd5; sizeY = 5'd10; m_ready_i = 1'b1;
    xf = 0; reached = 1'b0;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (m_valid_o && m_ready_i) xf++;
      if (xf == 4) reached = 1'b1;
    end
    check("abort_reached_4", reached, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset_midrun");
    #2;
    rst = 1'b0;
    run(5'd3, 5'd3, 0, 5, 1'b0);
    run(5'd3, 5'd3, 1, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
